// File: rtl/priv_timer_irq_src.sv
// priv_timer_irq_src: mtime/mtimecmp/msip register window with a two-cycle bus FSM,
// producing machine timer/software/external interrupt sources and their fall-clear pulses.
module priv_timer_irq_src #(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    input  logic        ren,
    input  logic        wen,
    output logic [31:0] rdata,
    output logic        busy,
    input  logic        ext_irq_async,
    output logic        timer_int_m,
    output logic        soft_int_m,
    output logic        ext_int_m,
    output logic        clear_timer_int_m,
    output logic        clear_soft_int_m,
    output logic        clear_ext_int_m
);
    typedef enum logic {IDLE, ACCESS} state_t;
    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
    state_t      r_state;
    logic [15:0] r_presc;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic        r_timer;
    logic        r_sync1;
    logic        r_sync2;
    logic [2:0]  r_int_d;
    logic [2:0]  r_clr;
    logic [31:0] w_off;
    logic [31:0] w_rd;
    logic [2:0]  w_int;
    logic        w_wr;
    logic        w_tick;
    logic        w_wr_msip;
    logic        w_wr_cmp_lo;
    logic        w_wr_cmp_hi;
    logic        w_wr_mt_lo;
    logic        w_wr_mt_hi;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? d[8*i +: 8] : old[8*i +: 8];
        return m;
    endfunction

    assign w_off       = addr - BASE_ADDR;
    assign w_wr        = (r_state == ACCESS) && wen;
    assign w_tick      = r_presc == DIV_LAST;
    assign w_wr_msip   = w_wr && w_off == 32'h0000_0000;
    assign w_wr_cmp_lo = w_wr && w_off == 32'h0000_4000;
    assign w_wr_cmp_hi = w_wr && w_off == 32'h0000_4004;
    assign w_wr_mt_lo  = w_wr && w_off == 32'h0000_BFF8;
    assign w_wr_mt_hi  = w_wr && w_off == 32'h0000_BFFC;
    assign w_int       = {r_timer, r_msip, r_sync2};

    always_comb begin
        w_rd = w_off == 32'h0000_0000 ? {31'b0, r_msip} :
               w_off == 32'h0000_4000 ? r_mtimecmp[31:0] :
               w_off == 32'h0000_4004 ? r_mtimecmp[63:32] :
               w_off == 32'h0000_BFF8 ? r_mtime[31:0] :
               w_off == 32'h0000_BFFC ? r_mtime[63:32] : 32'h0;
        rdata = (r_state == ACCESS && ren && !wen) ? w_rd : 32'h0;
        busy  = nRST && r_state == IDLE && (ren || wen);
    end

    assign {timer_int_m, soft_int_m, ext_int_m} = w_int;
    assign {clear_timer_int_m, clear_soft_int_m, clear_ext_int_m} = r_clr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_presc    <= 16'd0;
            r_mtime    <= 64'd0;
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
            r_timer    <= 1'b0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_int_d    <= 3'b0;
            r_clr      <= 3'b0;
        end else begin
            r_state    <= (r_state == IDLE && (ren || wen)) ? ACCESS : IDLE;
            r_presc    <= w_tick ? 16'd0 : r_presc + 16'd1;
            // a bus write to either mtime half wins over the tick in that cycle
            r_mtime    <= (w_wr_mt_lo || w_wr_mt_hi) ?
                          {w_wr_mt_hi ? merge(r_mtime[63:32], wdata, byte_en) : r_mtime[63:32],
                           w_wr_mt_lo ? merge(r_mtime[31:0], wdata, byte_en) : r_mtime[31:0]} :
                          r_mtime + {63'b0, w_tick};
            r_mtimecmp <= {w_wr_cmp_hi ? merge(r_mtimecmp[63:32], wdata, byte_en) : r_mtimecmp[63:32],
                           w_wr_cmp_lo ? merge(r_mtimecmp[31:0], wdata, byte_en) : r_mtimecmp[31:0]};
            r_msip     <= (w_wr_msip && byte_en[0]) ? wdata[0] : r_msip;
            r_timer    <= r_mtime >= r_mtimecmp;
            r_sync1    <= ext_irq_async;
            r_sync2    <= r_sync1;
            r_int_d    <= w_int;
            r_clr      <= r_int_d & ~w_int;
        end
    end
endmodule

// File: tb/tb_priv_timer_irq_src.sv
// tb_priv_timer_irq_src: directed bench for priv_timer_irq_src with a read-data scoreboard,
// using a TICK_DIV=1 instance at the default base and a TICK_DIV=4 instance at another base.
module tb_priv_timer_irq_src;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  byte_en = '0;
    logic [1:0]  ren = '0;
    logic [1:0]  wen = '0;
    logic        ext = 1'b0;
    wire  [31:0] rdata [2];
    wire  [1:0]  busy, tmr, sft, exo, clr_t, clr_s, clr_e;
    logic [31:0] sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          ecnt;

    priv_timer_irq_src #(.TICK_DIV(1)) dut (
        .CLK(CLK), .nRST(nRST), .addr(addr), .wdata(wdata), .byte_en(byte_en),
        .ren(ren[0]), .wen(wen[0]), .rdata(rdata[0]), .busy(busy[0]), .ext_irq_async(ext),
        .timer_int_m(tmr[0]), .soft_int_m(sft[0]), .ext_int_m(exo[0]),
        .clear_timer_int_m(clr_t[0]), .clear_soft_int_m(clr_s[0]), .clear_ext_int_m(clr_e[0])
    );

    priv_timer_irq_src #(.TICK_DIV(4), .BASE_ADDR(32'h1000_0000)) dut4 (
        .CLK(CLK), .nRST(nRST), .addr(addr), .wdata(wdata), .byte_en(byte_en),
        .ren(ren[1]), .wen(wen[1]), .rdata(rdata[1]), .busy(busy[1]), .ext_irq_async(ext),
        .timer_int_m(tmr[1]), .soft_int_m(sft[1]), .ext_int_m(exo[1]),
        .clear_timer_int_m(clr_t[1]), .clear_soft_int_m(clr_s[1]), .clear_ext_int_m(clr_e[1])
    );

    always #5 CLK = ~CLK;

    // edges since reset release: mtime of the TICK_DIV=1 instance equals this when unwritten
    always @(posedge CLK or negedge nRST)
        if (!nRST) ecnt <= 0;
        else ecnt <= ecnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] base(input int idx);
        return idx == 1 ? 32'h1000_0000 : 32'h0200_0000;
    endfunction

    // called just after a rising edge; returns just after the edge that completes the access
    task automatic bus(input int idx, input logic r, input logic w, input logic [15:0] off,
                       input logic [31:0] d, input logic [3:0] be, input string tag);
        int nb = 0;
        logic done = 1'b0;
        logic [31:0] exp;
        addr = base(idx) + {16'h0, off};
        wdata = d;
        byte_en = be;
        ren[idx] = r;
        wen[idx] = w;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge CLK);
            if (busy[idx]) begin
                nb++;
                @(posedge CLK);
                #1;
            end else done = 1'b1;
        end
        exp = sb_q.pop_front();
        chk({tag, "_done"}, {63'b0, done}, 64'd1);
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd1);
        chk(tag, {32'b0, rdata[idx]}, {32'b0, exp});
        @(posedge CLK);
        #1;
        ren[idx] = 1'b0;
        wen[idx] = 1'b0;
    endtask

    task automatic rd(input int idx, input logic [15:0] off, input logic [31:0] exp, input string tag);
        sb_q.push_back(exp);
        bus(idx, 1'b1, 1'b0, off, 32'h0, 4'h0, tag);
    endtask

    task automatic wr(input int idx, input logic [15:0] off, input logic [31:0] d,
                      input logic [3:0] be, input string tag);
        sb_q.push_back(32'h0);
        bus(idx, 1'b0, 1'b1, off, d, be, tag);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_rdata", {32'b0, rdata[0]}, 64'd0);
        chk("rst_busy", {62'b0, busy}, 64'd0);
        chk("rst_timer", {62'b0, tmr}, 64'd0);
        chk("rst_soft", {62'b0, sft}, 64'd0);
        chk("rst_ext", {62'b0, exo}, 64'd0);
        chk("rst_clears", {58'b0, clr_t, clr_s, clr_e}, 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        rd(0, 16'hBFF8, 32'(ecnt + 1), "mtime_lo_div1");
        rd(0, 16'hBFFC, 32'h0, "mtime_hi_div1");
        for (int i = 0; i < 4; i++) rd(1, 16'hBFF8, 32'((ecnt + 1) / 4), "mtime_lo_div4");
        rd(1, 16'h1234, 32'h0, "unmapped_rd");
        wr(1, 16'h0008, 32'hFFFF_FFFF, 4'hF, "unmapped_wr");
        sb_q.push_back(32'h0);
        bus(1, 1'b1, 1'b1, 16'h0000, 32'h1, 4'h1, "ren_wen_as_write");
        @(negedge CLK);
        chk("ren_wen_soft4", {63'b0, sft[1]}, 64'd1);
        chk("ren_wen_soft_other", {63'b0, sft[0]}, 64'd0);
        @(posedge CLK);
        #1;
        rd(1, 16'h0000, 32'h1, "msip4_rd");

        wr(0, 16'h0000, 32'h1, 4'b0001, "msip_set");
        @(negedge CLK);
        chk("soft_set", {63'b0, sft[0]}, 64'd1);
        @(posedge CLK);
        #1;
        wr(0, 16'h0000, 32'h0, 4'b0000, "msip_be0");
        @(negedge CLK);
        chk("soft_be0_kept", {63'b0, sft[0]}, 64'd1);
        @(posedge CLK);
        #1;
        wr(0, 16'h0000, 32'hFFFF_FFFF, 4'hF, "msip_all");
        rd(0, 16'h0000, 32'h1, "msip_rd_bit0");
        wr(0, 16'h0000, 32'h0, 4'b0001, "msip_clr");
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("soft_fall", {63'b0, sft[0]}, 64'd0);
            chk("clr_soft_pulse", {63'b0, clr_s[0]}, {63'b0, k == 1});
        end
        @(posedge CLK);
        #1;

        wr(0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, "mt_hi_max");
        wr(0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, "mt_lo_max");
        rd(0, 16'hBFF8, 32'h0, "wrap_lo");
        rd(0, 16'hBFFC, 32'h0, "wrap_hi");
        wr(0, 16'hBFF8, 32'h0000_0100, 4'hF, "mt_lo_tick");
        rd(0, 16'hBFF8, 32'h0000_0101, "tick_write_exact");

        wr(0, 16'h4000, 32'h5, 4'hF, "cmp_lo");
        wr(0, 16'hBFF8, 32'h0, 4'hF, "mt_lo_zero");
        wr(0, 16'h4004, 32'h0, 4'hF, "cmp_hi");
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            chk("timer_rise", {63'b0, tmr[0]}, {63'b0, k >= 4});
        end
        @(posedge CLK);
        #1;
        rd(0, 16'h4000, 32'h5, "cmp_lo_rd");
        wr(0, 16'h4004, 32'h1, 4'hF, "cmp_hi_one");
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("timer_fall", {63'b0, tmr[0]}, {63'b0, k == 0});
            chk("clr_timer_pulse", {63'b0, clr_t[0]}, {63'b0, k == 2});
        end
        @(posedge CLK);
        #1;
        rd(0, 16'h4004, 32'h1, "cmp_hi_rd");

        ext = 1'b1;
        n = 0;
        for (int i = 0; i < 6 && !exo[0]; i++) begin
            @(negedge CLK);
            n++;
        end
        chk("ext_rise_cycles", 64'(n), 64'd3);
        chk("ext_rise_div4", {63'b0, exo[1]}, 64'd1);
        @(posedge CLK);
        #1;
        ext = 1'b0;
        n = 0;
        for (int i = 0; i < 6 && exo[0]; i++) begin
            @(negedge CLK);
            n++;
        end
        chk("ext_fall_cycles", 64'(n), 64'd3);
        for (int k = 0; k < 3; k++) begin
            chk("clr_ext_pulse", {63'b0, clr_e[0]}, {63'b0, k == 1});
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;

        ext = 1'b1;
        wr(0, 16'h0000, 32'h1, 4'h1, "msip_pre_rst");
        @(negedge CLK);
        chk("pre_rst_soft", {63'b0, sft[0]}, 64'd1);
        chk("pre_rst_ext", {63'b0, exo[0]}, 64'd1);
        @(posedge CLK);
        #1;
        addr = base(0) + 32'h4000;
        wdata = 32'h0;
        byte_en = 4'hF;
        wen[0] = 1'b1;
        @(negedge CLK);
        chk("abort_busy_idle", {63'b0, busy[0]}, 64'd1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("abort_busy_access", {63'b0, busy[0]}, 64'd0);
        #1;
        nRST = 1'b0;
        ext = 1'b0;
        #1;
        chk("abort_busy", {63'b0, busy[0]}, 64'd0);
        chk("abort_rdata", {32'b0, rdata[0]}, 64'd0);
        chk("abort_ints", {61'b0, tmr[0], sft[0], exo[0]}, 64'd0);
        chk("abort_clears", {61'b0, clr_t[0], clr_s[0], clr_e[0]}, 64'd0);
        wen[0] = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        rd(0, 16'h4000, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(0, 16'h4004, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(0, 16'h0000, 32'h0, "rst_msip");
        rd(0, 16'hBFF8, 32'(ecnt + 1), "rst_mtime_lo");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
